wb_regfile: RTL

- Write-back stage and integer register file of the five-stage pipeline; consumes the MEM/WB pipeline register outputs.
- Selects the ALU or memory result and commits it to a 32-entry register file at the clock edge.
- Serves the two ID-stage read ports, with write-to-read bypass in the same cycle.
- Exports the selected write-back value for EX forwarding, plus write statistics and last-write trace registers.

---
 rtl/wb_regfile.sv | 84 ++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Write-back stage and integer register file: selects the ALU or load result,
// commits it to the register file, and serves two ID read ports with same-cycle bypass.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_aluOut_WB_memOut,
    input  logic             wb_writeReg,
    input  logic [XLEN-1:0]  wb_outMem,
    input  logic [XLEN-1:0]  wb_outAlu,
    input  logic [AW-1:0]    wb_rd,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    output logic [XLEN-1:0]  id_rdata1,
    output logic [XLEN-1:0]  id_rdata2,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_we_eff,
    output logic [CNT_W-1:0] wr_count,
    output logic [AW-1:0]    last_wr_rd,
    output logic [XLEN-1:0]  last_wr_data
);

    logic [XLEN-1:0]  r_regs [NREG];
    logic [CNT_W-1:0] r_wr_count;
    logic [AW-1:0]    r_last_wr_rd;
    logic [XLEN-1:0]  r_last_wr_data;

    logic [XLEN-1:0]  w_wb_data;
    logic             w_rd_in_range;
    logic             w_we_eff;
    logic [AW-1:0]    w_rs    [2];
    logic [XLEN-1:0]  w_rdata [2];

    assign w_wb_data     = wb_aluOut_WB_memOut ? wb_outMem : wb_outAlu;
    assign w_rd_in_range = (32'(wb_rd) < NREG);
    // Gating with rst keeps both the commit and the bypass quiet during reset.
    assign w_we_eff      = wb_writeReg && (wb_rd != '0) && w_rd_in_range && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count     <= '0;
            r_last_wr_rd   <= '0;
            r_last_wr_data <= '0;
        end else if (w_we_eff) begin
            r_regs[wb_rd]  <= w_wb_data;
            r_wr_count     <= r_wr_count + 1'b1;
            r_last_wr_rd   <= wb_rd;
            r_last_wr_data <= w_wb_data;
        end
    end

    assign w_rs[0] = id_rs1;
    assign w_rs[1] = id_rs2;

    // Both read ports share one priority: x0 / out-of-range, then bypass, then array.
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        always_comb begin
            w_rdata[p] = '0;
            if (w_rs[p] == '0 || 32'(w_rs[p]) >= NREG) begin
                w_rdata[p] = '0;
            end else if (w_we_eff && w_rs[p] == wb_rd) begin
                w_rdata[p] = w_wb_data;
            end else begin
                w_rdata[p] = r_regs[w_rs[p]];
            end
        end
    end

    assign id_rdata1    = w_rdata[0];
    assign id_rdata2    = w_rdata[1];
    assign wb_data      = w_wb_data;
    assign wb_we_eff    = w_we_eff;
    assign wr_count     = r_wr_count;
    assign last_wr_rd   = r_last_wr_rd;
    assign last_wr_data = r_last_wr_data;

endmodule
